// File: rtl/fredkin_mm_pkg.sv
// Shared types and sizing helpers for the Fredkin shift-add multiplier slice.
package fredkin_mm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int WIDTH_DEF     = 8;
  localparam int ACC_GUARD_DEF = 4;

  function automatic int res_w(input int width, input int guard);
    return 2 * width + guard;
  endfunction
endpackage

// File: rtl/fredkin_gate.sv
// Fredkin (controlled-swap) gate: p=x; x=1 swaps y and z onto q/r.
module fredkin_gate (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic p,
  output logic q,
  output logic r
);
  assign p = x;
  assign q = x ? z : y;
  assign r = x ? y : z;
endmodule

// File: rtl/fredkin_pp_row.sv
// One partial-product row: each Fredkin gate passes mcand[i] on q when sel is high.
module fredkin_pp_row #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] pp
);
  // Only the q outputs carry the partial product; p and r are by-products.
  logic [WIDTH-1:0] p_unused;
  logic [WIDTH-1:0] r_unused;

  for (genvar i = 0; i < WIDTH; i++) begin : g_gate
    fredkin_gate u_gate (
      .x (sel),
      .y (1'b0),
      .z (mcand[i]),
      .p (p_unused[i]),
      .q (pp[i]),
      .r (r_unused[i])
    );
  end
endmodule

// File: rtl/fredkin_shift_add_ctrl.sv
// Sequential shift-add multiplier controller driving a Fredkin partial-product row.
// Define FREDKIN_ACCUM_EN to add the in_clr port and a wrapping result accumulator.
module fredkin_shift_add_ctrl
  import fredkin_mm_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int ACC_GUARD = ACC_GUARD_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_a,
  input  logic [WIDTH-1:0]                    in_b,
`ifdef FREDKIN_ACCUM_EN
  input  logic                                in_clr,
`endif
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [res_w(WIDTH, ACC_GUARD)-1:0]  out_result,
  output logic                                busy
);
  localparam int RES_W  = res_w(WIDTH, ACC_GUARD);
  localparam int PROD_W = 2 * WIDTH;
  localparam int CNT_W  = $clog2(WIDTH);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [WIDTH-1:0]    mcand_q;
  logic [WIDTH-1:0]    mplier_q;
  logic [PROD_W-1:0]   product_q;
  logic [RES_W-1:0]    out_result_q;
  logic                out_valid_q;
  logic                in_ready_q;
  logic                busy_q;

  logic [WIDTH-1:0]    pp;
  logic [PROD_W-1:0]   product_d;
  logic [RES_W-1:0]    result_d;

  fredkin_pp_row #(.WIDTH(WIDTH)) u_row (
    .sel   (mplier_q[0]),
    .mcand (mcand_q),
    .pp    (pp)
  );

  assign product_d = product_q + ({{WIDTH{1'b0}}, pp} << cnt_q);

`ifdef FREDKIN_ACCUM_EN
  logic [RES_W-1:0] acc_q;
  logic             clr_q;
  // Sum wraps naturally at RES_W bits.
  assign result_d = (clr_q ? '0 : acc_q) + {{ACC_GUARD{1'b0}}, product_d};
`else
  assign result_d = {{ACC_GUARD{1'b0}}, product_d};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      product_q    <= '0;
      out_result_q <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
`ifdef FREDKIN_ACCUM_EN
      acc_q        <= '0;
      clr_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_q    <= in_a;
            mplier_q   <= in_b;
            product_q  <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
`ifdef FREDKIN_ACCUM_EN
            clr_q      <= in_clr;
`endif
          end
        end
        RUN: begin
          product_q <= product_d;
          mplier_q  <= mplier_q >> 1;
          cnt_q     <= cnt_q + CNT_W'(1);
          // Last partial product: publish the finished sum on this edge.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            out_result_q <= result_d;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
`ifdef FREDKIN_ACCUM_EN
            acc_q        <= result_d;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_fredkin_shift_add_ctrl.sv
// Directed self-checking bench for fredkin_shift_add_ctrl (WIDTH=8, ACC_GUARD=4).
module tb_fredkin_shift_add_ctrl;
  localparam int WIDTH = 8;
  localparam int RES_W = 20;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_clr;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  fredkin_shift_add_ctrl #(.WIDTH(WIDTH), .ACC_GUARD(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
`ifdef FREDKIN_ACCUM_EN
    .in_clr     (in_clr),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operand pair, wait for out_valid, check latency and value; leaves result in DONE.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic clr, input logic [31:0] exp);
    int n;
    in_a = a; in_b = b; in_clr = clr; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_result"}, 32'(out_result), exp);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int c1, c2, cyc, nvalid, ready_bad;
    logic [31:0] r1, r2;
    logic seen;

    rst_n = 1'b0; in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5; in_clr = 1'b0; out_ready = 1'b0;
    tick(); tick(); tick();
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy), 32'd0);

    // 13*11 with downstream stalled.
    run_op("mul13x11", 8'd13, 8'd11, 1'b1, 32'd143);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid",  32'(out_valid),  32'd1);
      chk("stall_result", 32'(out_result), 32'd143);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    release_out();
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_ready", 32'(in_ready),  32'd1);

    run_op("mul255x255", 8'd255, 8'd255, 1'b1, 32'd65025);
    release_out();
    run_op("mul0x200", 8'd0, 8'd200, 1'b1, 32'd0);
    release_out();

    // Back-to-back with in_valid held and out_ready high.
    in_a = 8'd9; in_b = 8'd9; in_valid = 1'b1; out_ready = 1'b1;
    c1 = -1; c2 = -1; r1 = '0; r2 = '0; ready_bad = 0; cyc = 0;
    while (c2 < 0 && cyc < 60) begin
      tick();
      cyc++;
      if (busy && in_ready) ready_bad++;
      if (out_valid) begin
        if (c1 < 0) begin
          c1 = cyc; r1 = 32'(out_result); in_a = 8'd10; in_b = 8'd10;
        end else begin
          c2 = cyc; r2 = 32'(out_result); in_valid = 1'b0;
        end
      end
    end
    chk("b2b_ready_low_when_busy", 32'(ready_bad), 32'd0);
    chk("b2b_first",  r1, 32'd81);
    chk("b2b_second", r2, 32'd100);
    chk("b2b_interval", 32'(c2 - c1), 32'd10);
    tick();
    out_ready = 1'b0;
    tick();
    chk("b2b_idle", 32'(busy), 32'd0);

    // Reset in the 4th RUN cycle aborts the operation.
    in_a = 8'd100; in_b = 8'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy",     32'(busy),      32'd0);
    chk("abort_in_ready", 32'(in_ready),  32'd1);
    chk("abort_valid",    32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) nvalid++;
    end
    chk("abort_no_result", 32'(nvalid), 32'd0);
    out_ready = 1'b0;
    run_op("mul6x7", 8'd6, 8'd7, 1'b1, 32'd42);
    release_out();

`ifdef FREDKIN_ACCUM_EN
    run_op("acc_3x4_clr", 8'd3, 8'd4, 1'b1, 32'd12);
    release_out();
    run_op("acc_5x6", 8'd5, 8'd6, 1'b0, 32'd42);
    release_out();
    run_op("acc_2x2_clr", 8'd2, 8'd2, 1'b1, 32'd4);
    release_out();
    // 4 + 16*65025 = 1040404 -> mod 2^20 = 1040404 - 1048576 wraps after the 17th add.
    r1 = 32'd4;
    for (int i = 0; i < 17; i++) begin
      r1 = (r1 + 32'd65025) & 32'h000F_FFFF;
      run_op("acc_wrap", 8'd255, 8'd255, 1'b0, r1);
      release_out();
    end
    chk("acc_wrapped_value", r1, 32'd56853);
`endif

    seen = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
